// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INSTR_W          : instruction word width
//   RESET_PC_DEFAULT : default PC loaded on reset
//   fetch_state_e    : fetch FSM states (S_BOOT, S_RUN, S_DRAIN)
//   queue_entry_t    : one instruction-queue record {instr, pc}
package instruction_fetch_unit_pkg;

   localparam int unsigned INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
   } queue_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle of the instruction fetch unit: instruction-memory request/response,
// redirect input and the decode-side valid/ready handshake.
//   master : the fetch unit side
//   slave  : memory / branch unit / decoder side
interface instruction_fetch_unit_if;
   import instruction_fetch_unit_pkg::*;

   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [31:0]        imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               id_valid;
   logic               id_ready;
   logic [INSTR_W-1:0] id_instruction;
   logic [31:0]        id_pc;
   logic [31:0]        id_pc_plus4;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc,
      output id_valid, id_instruction, id_pc, id_pc_plus4,
      input  id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc,
      input  id_valid, id_instruction, id_pc, id_pc_plus4,
      output id_ready
   );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: synchronous in-order FIFO with flush.
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared to 0)
//   push/push_data, pop : enqueue / dequeue (push on full is accepted only with a pop)
//   flush      : empties the queue, takes priority over push/pop
//   head_data  : registered head entry
//   full, empty, count : occupancy status
module fetch_queue #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   assign count     = wr_ptr_q - rd_ptr_q;
   assign full      = (count == DEPTH_W);
   assign empty     = (count == '0);
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_data = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
            wr_ptr_q                <= wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage feeding the instruction decoder.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : master side of instruction_fetch_unit_if
//           imem_req_*  word read requests at the PC
//           imem_rsp_*  in-order read data
//           redirect_*  jump/branch taken, flush and refetch
//           id_*        {instruction, pc, pc+4} to decode with valid/ready
// Requests are credited so that queued words plus in-flight reads never exceed
// QUEUE_DEPTH; a response therefore always finds room in the queue.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input logic                      clk,
   input logic                      rst_n,
   instruction_fetch_unit_if.master bus
);

   localparam int unsigned CW      = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW:0]   DEPTH_X = (CW + 1)'(QUEUE_DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   // PC of the next response that will be kept (oldest non-discarded read).
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;

   logic          redirect, credit_ok, req_valid, req_fire, rsp_ok;
   logic          q_push, q_pop, q_full, q_empty;
   logic [CW-1:0] q_count;
   queue_entry_t  q_push_data, q_head;

   // Redirects are ignored while booting.
   assign redirect  = bus.redirect_valid & (state_q != S_BOOT);
   assign credit_ok = ~q_full & (({1'b0, q_count} + {1'b0, outstanding_q}) < DEPTH_X);
   assign req_valid = (state_q == S_RUN) & ~redirect & credit_ok;
   assign req_fire  = req_valid & bus.imem_req_ready;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_ok    = bus.imem_rsp_valid & (outstanding_q != '0);
   assign q_push    = rsp_ok & (discard_q == '0) & ~redirect & (state_q == S_RUN);
   assign q_pop     = bus.id_valid & bus.id_ready;

   assign q_push_data = '{instr: bus.imem_rsp_data, pc: rsp_pc_q};

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH ($bits(queue_entry_t))
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .flush     (redirect),
      .head_data (q_head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;

      if (req_fire) begin
         pc_d          = pc_q + 32'd4;
         outstanding_d = outstanding_d + CNT_ONE;
      end
      if (rsp_ok) begin
         outstanding_d = outstanding_d - CNT_ONE;
         if (discard_q != '0) begin
            discard_d = discard_q - CNT_ONE;
         end
      end
      if (q_push) begin
         rsp_pc_d = rsp_pc_q + 32'd4;
      end

      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         S_DRAIN: if (discard_d == '0) state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase

      // Everything still in flight after this cycle's accounting is stale.
      if (redirect) begin
         pc_d      = {bus.redirect_pc[31:2], 2'b00};
         rsp_pc_d  = {bus.redirect_pc[31:2], 2'b00};
         discard_d = outstanding_d;
         state_d   = (outstanding_d != '0) ? S_DRAIN : S_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_BOOT;
         pc_q          <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   // Redirect masks the head so no transfer happens in a redirect cycle.
   assign bus.id_valid       = ~q_empty & ~bus.redirect_valid;
   assign bus.id_instruction = q_head.instr;
   assign bus.id_pc          = q_head.pc;
   assign bus.id_pc_plus4    = q_head.pc + 32'd4;

endmodule
